iob_cache_line_fill: RTL and testbench
======================================

Name: iob_cache_line_fill

Overview:
- Initiator-side controller that drives the byte-enable single-port cache data RAM during a line refill.
- Accepts a fill command from the cache control logic and issues one burst read to the back-end.
- Writes each returned beat into consecutive words of the target line with all byte enables set.
- Sits between the back-end read channel and the data-RAM write port.

Parameters:
- DATA_W, 32, data word width; multiple of 8.
- ADDR_W, 10, RAM word-address width.
- LINE_OFF_W, 2, log2 of words per line; WORDS = 2**LINE_OFF_W.
- BE_ADDR_W, 32, back-end byte-address width.

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- arst_n_i  in  1  asynchronous, active-low reset.
- fill_req_i  in  1  start a fill; sampled only in IDLE.
- fill_addr_i  in  BE_ADDR_W  back-end line address; low LINE_OFF_W+log2(DATA_W/8) bits ignored.
- fill_line_i  in  ADDR_W-LINE_OFF_W  target RAM line index.
- fill_busy_o  out  1  high in every state except IDLE.
- fill_done_o  out  1  one-cycle pulse when the fill completes.
- be_valid_o  out  1  back-end burst request.
- be_addr_o  out  BE_ADDR_W  line-aligned burst address.
- be_ready_i  in  1  back-end accepts the request.
- be_rvalid_i  in  1  read-data beat valid.
- be_rdata_i  in  DATA_W  read-data beat.
- ram_en_o  out  1  RAM enable.
- ram_we_o  out  DATA_W/8  RAM byte write enables.
- ram_addr_o  out  ADDR_W  RAM word address.
- ram_data_o  out  DATA_W  RAM write data.

Behaviour:
- Reset: all outputs 0; state IDLE; beat counter 0. Async assert takes effect immediately and aborts any fill; no further RAM writes occur.
- IDLE:
  - On fill_req_i=1, latch fill_line_i and line-aligned fill_addr_i, then go to REQ.
  - fill_busy_o rises the next cycle.
- REQ:
  - be_valid_o=1 and be_addr_o holds the latched address, both stable until be_ready_i=1.
  - The cycle with be_valid_o&be_ready_i transfers to RECV; be_valid_o=0 from the next cycle.
- RECV:
  - Each cycle with be_rvalid_i=1 registers one RAM write.
  - Write appears next cycle: ram_en_o=1, ram_we_o=all ones, ram_addr_o={line, cnt}, ram_data_o=be_rdata_i.
  - cnt then increments.
  - Cycles without be_rvalid_i: ram_en_o=0, ram_we_o=0.
  - On the beat with cnt=WORDS-1, go to DONE; cnt wraps to 0.
- DONE:
  - The final RAM write and fill_done_o=1 occur in this same single cycle.
  - Return to IDLE; fill_busy_o drops the cycle after.
- Latency: beat k written one cycle after acceptance. Minimum command-to-done is WORDS+2 cycles with be_ready_i and be_rvalid_i tied high.
- be_rvalid_i in IDLE/REQ: ignored, never written.
- fill_req_i while busy: ignored, not queued.
- fill_req_i in the DONE cycle: ignored; the requester must re-assert in IDLE.
- ram_addr_o/ram_data_o hold their last value when ram_en_o=0.

Optional Feature:
- Macro: IOB_CACHE_LINE_FILL_ERR_EN.
- When defined:
  - Adds input be_rerr_i (qualified by be_rvalid_i) and output fill_err_o.
  - An error beat is not written to RAM; go to DONE with fill_err_o=1 and fill_done_o=1 in the same cycle.
  - Remaining beats are ignored until the next fill.
- When undefined: no extra ports; all beats are written.

Decomposition:
- Package iob_cache_line_fill_pkg:
  - State encoding localparams IDLE=2'd0, REQ=2'd1, RECV=2'd2, DONE=2'd3.
  - WORDS and byte-offset width helpers.
- Natural sub-module: iob_cache_fill_beat_cnt, a LINE_OFF_W-bit counter with clear, enable and terminal-count output.

Test Plan:
- Basic fill: DATA_W=32, LINE_OFF_W=2, fill_addr_i=0x1234, fill_line_i=5, ready/rvalid tied high, data 0xA0..0xA3.
  - be_addr_o=0x1230.
  - RAM writes to addresses 20,21,22,23 with ram_we_o=4'hF.
  - fill_done_o pulses in cycle 6 after the request.
- Back-pressure: be_ready_i low 3 cycles, rvalid gaps of 2 cycles between beats.
  - be_valid_o and be_addr_o stable throughout.
  - Exactly 4 writes; no write in gap cycles.
- Ignored inputs: fill_req_i=1 and be_rvalid_i pulses while in REQ.
  - No second request; no RAM write; single fill_done_o.
- Reset mid-fill: arst_n_i low after beat 2.
  - All outputs 0 immediately; no further writes.
  - A new fill to line 1 then writes addresses 4..7 from cnt 0.
- Wrap: fill_line_i=255 (ADDR_W=10).
  - Writes to addresses 1020..1023; counter returns to 0.
- IOB_CACHE_LINE_FILL_ERR_EN: be_rerr_i=1 on beat 1.
  - Only address {line,0} written.
  - fill_err_o and fill_done_o both pulse.
  - Beats 2..3 are not written.

Source files
------------

// File: rtl/iob_cache_line_fill_pkg.sv
// -----------------------------------------------------------------------------
// iob_cache_line_fill_pkg
// Shared types and sizing helpers for the cache line-fill controller.
//   fill_state_e  : controller state encoding (IDLE/REQ/RECV/DONE)
//   words_f       : words per line from the line-offset width
//   byte_off_w_f  : byte-offset width of one data word
// -----------------------------------------------------------------------------
package iob_cache_line_fill_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } fill_state_e;

    function automatic int unsigned words_f(input int unsigned line_off_w);
        return 32'd1 << line_off_w;
    endfunction

    function automatic int unsigned byte_off_w_f(input int unsigned data_w);
        return $clog2(data_w / 32'd8);
    endfunction

endpackage

// File: rtl/iob_cache_fill_beat_cnt.sv
// -----------------------------------------------------------------------------
// iob_cache_fill_beat_cnt
// Beat counter selecting the word within the line being refilled.
// Ports:
//   clk_i, arst_n_i : clock, asynchronous active-low reset
//   clr_i           : synchronous clear (start of a fill, aborted fill)
//   en_i            : advance by one beat; wraps to 0 after the last word
//   cnt_o           : current word offset
//   tc_o            : high while cnt_o addresses the last word of the line
// -----------------------------------------------------------------------------
module iob_cache_fill_beat_cnt
    import iob_cache_line_fill_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         arst_n_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_r;

    // Word-offset counter; natural wrap on the last beat returns it to 0.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cnt_r <= '0;
        end else if (clr_i) begin
            cnt_r <= '0;
        end else if (en_i) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt_o = cnt_r;
    assign tc_o  = (cnt_r == W'(words_f(W) - 32'd1));

endmodule

// File: rtl/iob_cache_line_fill.sv
// -----------------------------------------------------------------------------
// iob_cache_line_fill
// Line-refill controller: takes a fill command, issues one burst read to the
// back-end and writes each returned beat into consecutive words of the target
// line of the byte-enable data RAM (all byte enables set).
// Ports:
//   clk_i, arst_n_i                 : clock, asynchronous active-low reset
//   fill_req_i/addr_i/line_i        : fill command (sampled only in IDLE)
//   fill_busy_o, fill_done_o        : busy level, one-cycle completion pulse
//   be_valid_o/addr_o, be_ready_i   : back-end burst request handshake
//   be_rvalid_i, be_rdata_i         : back-end read beats
//   ram_en_o/we_o/addr_o/data_o     : data-RAM write port (registered)
// Optional build macro IOB_CACHE_LINE_FILL_ERR_EN adds be_rerr_i/fill_err_o:
// an error beat is dropped and ends the fill with fill_err_o+fill_done_o.
// -----------------------------------------------------------------------------
module iob_cache_line_fill
    import iob_cache_line_fill_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int LINE_OFF_W = 2,
    parameter int BE_ADDR_W  = 32
) (
    input  logic                         clk_i,
    input  logic                         arst_n_i,
    input  logic                         fill_req_i,
    input  logic [BE_ADDR_W-1:0]         fill_addr_i,
    input  logic [ADDR_W-LINE_OFF_W-1:0] fill_line_i,
    output logic                         fill_busy_o,
    output logic                         fill_done_o,
`ifdef IOB_CACHE_LINE_FILL_ERR_EN
    input  logic                         be_rerr_i,
    output logic                         fill_err_o,
`endif
    output logic                         be_valid_o,
    output logic [BE_ADDR_W-1:0]         be_addr_o,
    input  logic                         be_ready_i,
    input  logic                         be_rvalid_i,
    input  logic [DATA_W-1:0]            be_rdata_i,
    output logic                         ram_en_o,
    output logic [DATA_W/8-1:0]          ram_we_o,
    output logic [ADDR_W-1:0]            ram_addr_o,
    output logic [DATA_W-1:0]            ram_data_o
);

    localparam int LINE_W  = ADDR_W - LINE_OFF_W;
    localparam int ALIGN_W = LINE_OFF_W + int'(byte_off_w_f(DATA_W));
    // Clears the word and byte offset bits of the back-end address.
    localparam logic [BE_ADDR_W-1:0] ALIGN_MASK =
        ~((BE_ADDR_W'(1) << ALIGN_W) - BE_ADDR_W'(1));

    fill_state_e             state_r, next_state_s;
    logic [LINE_W-1:0]       line_r;
    logic [BE_ADDR_W-1:0]    be_addr_r;
    logic                    busy_r, valid_r, done_r;
    logic                    ram_en_r;
    logic [DATA_W/8-1:0]     ram_we_r;
    logic [ADDR_W-1:0]       ram_addr_r;
    logic [DATA_W-1:0]       ram_data_r;
    logic                    latch_s, cnt_clr_s, cnt_en_s, wr_s, err_s;
    logic                    beat_err_s, tc_s;
    logic [LINE_OFF_W-1:0]   cnt_s;

`ifdef IOB_CACHE_LINE_FILL_ERR_EN
    logic                    err_r;
    assign beat_err_s = be_rerr_i;
`else
    assign beat_err_s = 1'b0;
`endif

    iob_cache_fill_beat_cnt #(
        .W (LINE_OFF_W)
    ) u_beat_cnt (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .clr_i    (cnt_clr_s),
        .en_i     (cnt_en_s),
        .cnt_o    (cnt_s),
        .tc_o     (tc_s)
    );

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        next_state_s = state_r;
        latch_s      = 1'b0;
        cnt_clr_s    = 1'b0;
        cnt_en_s     = 1'b0;
        wr_s         = 1'b0;
        err_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (fill_req_i) begin
                    latch_s      = 1'b1;
                    cnt_clr_s    = 1'b1;
                    next_state_s = REQ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            REQ: begin
                if (be_ready_i) begin
                    next_state_s = RECV;
                end else begin
                    next_state_s = REQ;
                end
            end
            RECV: begin
                if (be_rvalid_i && beat_err_s) begin
                    // Drop the bad beat; restart the offset for the next fill.
                    err_s        = 1'b1;
                    cnt_clr_s    = 1'b1;
                    next_state_s = DONE;
                end else if (be_rvalid_i) begin
                    wr_s     = 1'b1;
                    cnt_en_s = 1'b1;
                    if (tc_s) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = RECV;
                    end
                end else begin
                    next_state_s = RECV;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register and status outputs decoded from the next state.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != IDLE);
            valid_r <= (next_state_s == REQ);
            done_r  <= (next_state_s == DONE);
        end
    end

    // Fill command capture: target line and line-aligned burst address.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            line_r    <= '0;
            be_addr_r <= '0;
        end else if (latch_s) begin
            line_r    <= fill_line_i;
            be_addr_r <= fill_addr_i & ALIGN_MASK;
        end else begin
            line_r    <= line_r;
            be_addr_r <= be_addr_r;
        end
    end

    // RAM write port; address and data hold between writes.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ram_en_r   <= 1'b0;
            ram_we_r   <= '0;
            ram_addr_r <= '0;
            ram_data_r <= '0;
        end else if (wr_s) begin
            ram_en_r   <= 1'b1;
            ram_we_r   <= '1;
            ram_addr_r <= {line_r, cnt_s};
            ram_data_r <= be_rdata_i;
        end else begin
            ram_en_r   <= 1'b0;
            ram_we_r   <= '0;
            ram_addr_r <= ram_addr_r;
            ram_data_r <= ram_data_r;
        end
    end

`ifdef IOB_CACHE_LINE_FILL_ERR_EN
    // Error flag, pulsed alongside fill_done_o in the DONE cycle.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_s;
        end
    end

    assign fill_err_o = err_r;
`else
    logic unused_s;
    assign unused_s = err_s;
`endif

    assign fill_busy_o = busy_r;
    assign fill_done_o = done_r;
    assign be_valid_o  = valid_r;
    assign be_addr_o   = be_addr_r;
    assign ram_en_o    = ram_en_r;
    assign ram_we_o    = ram_we_r;
    assign ram_addr_o  = ram_addr_r;
    assign ram_data_o  = ram_data_r;

endmodule

// File: tb/tb_iob_cache_line_fill.sv
// Directed self-checking bench for iob_cache_line_fill (default parameters).
module tb_iob_cache_line_fill;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        fill_req;
    logic [31:0] fill_addr;
    logic [7:0]  fill_line;
    logic        fill_busy, fill_done;
    logic        be_valid;
    logic [31:0] be_addr;
    logic        be_ready, be_rvalid;
    logic [31:0] be_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_data;
`ifdef IOB_CACHE_LINE_FILL_ERR_EN
    logic        be_rerr;
    logic        fill_err;
`endif

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;
    int done_cnt = 0;
    int req_cnt = 0;
    int done_cyc = -1;
    logic [9:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [3:0]  wr_we_q[$];

    iob_cache_line_fill dut (
        .clk_i       (clk),
        .arst_n_i    (arst_n),
        .fill_req_i  (fill_req),
        .fill_addr_i (fill_addr),
        .fill_line_i (fill_line),
        .fill_busy_o (fill_busy),
        .fill_done_o (fill_done),
`ifdef IOB_CACHE_LINE_FILL_ERR_EN
        .be_rerr_i   (be_rerr),
        .fill_err_o  (fill_err),
`endif
        .be_valid_o  (be_valid),
        .be_addr_o   (be_addr),
        .be_ready_i  (be_ready),
        .be_rvalid_i (be_rvalid),
        .be_rdata_i  (be_rdata),
        .ram_en_o    (ram_en),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_data_o  (ram_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt++;

    // Capture RAM writes and handshakes mid-cycle.
    always @(negedge clk) begin
        if (ram_en === 1'b1) begin
            wr_addr_q.push_back(ram_addr);
            wr_data_q.push_back(ram_data);
            wr_we_q.push_back(ram_we);
        end
        if (fill_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc_cnt;
        end
        if (be_valid === 1'b1 && be_ready === 1'b1) req_cnt++;
    end

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_we_q.delete();
        done_cnt = 0;
        req_cnt  = 0;
        done_cyc = -1;
    endtask

    // Stimulus only: one fill with ready/rvalid tied high; ends at negedge of cycle 7.
    task automatic run_fast_fill(input logic [7:0] line, input logic [31:0] addr,
                                 input logic [31:0] base);
        @(posedge clk); #1;
        fill_req = 1'b1; fill_addr = addr; fill_line = line;
        be_ready = 1'b1; be_rvalid = 1'b1; be_rdata = 32'hDEAD_0000;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            fill_req = 1'b0;
            be_rdata = base + 32'(c - 2);
            if (c >= 6) be_rvalid = 1'b0;
        end
        @(negedge clk);
        be_ready = 1'b0;
    endtask

    task automatic test_reset();
        arst_n = 1'b0; fill_req = 1'b0; fill_addr = 32'h0; fill_line = 8'h0;
        be_ready = 1'b0; be_rvalid = 1'b0; be_rdata = 32'h0;
`ifdef IOB_CACHE_LINE_FILL_ERR_EN
        be_rerr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({fill_busy, fill_done, be_valid, ram_en} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got=%b exp=0000", {fill_busy, fill_done, be_valid, ram_en}); end
        checks++; if ({be_addr, ram_we, ram_addr, ram_data} !== 78'h0) begin
            errors++; $display("FAIL reset_buses got=%h exp=0", {be_addr, ram_we, ram_addr, ram_data}); end
        @(posedge clk); #1;
        arst_n = 1'b1;
    endtask

    task automatic test_basic();
        int start;
        clear_logs();
        @(posedge clk); #1;
        fill_req = 1'b1; fill_addr = 32'h0000_1234; fill_line = 8'd5;
        be_ready = 1'b1; be_rvalid = 1'b1; be_rdata = 32'hDEAD_0000;
        start = cyc_cnt;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            fill_req = 1'b0;
            be_rdata = (c >= 2) ? 32'hA0 + 32'(c - 2) : 32'hDEAD_0001;
            if (c >= 6) be_rvalid = 1'b0;
            @(negedge clk);
            checks++; if (fill_busy !== (c <= 6)) begin
                errors++; $display("FAIL basic_busy c=%0d got=%b exp=%b", c, fill_busy, (c <= 6)); end
            checks++; if (fill_done !== (c == 6)) begin
                errors++; $display("FAIL basic_done c=%0d got=%b exp=%b", c, fill_done, (c == 6)); end
            checks++; if (be_valid !== (c == 1)) begin
                errors++; $display("FAIL basic_valid c=%0d got=%b exp=%b", c, be_valid, (c == 1)); end
            if (c == 1) begin
                checks++; if (be_addr !== 32'h0000_1230) begin
                    errors++; $display("FAIL basic_be_addr got=%h exp=00001230", be_addr); end
            end
        end
        checks++; if (done_cyc - start !== 6) begin
            errors++; $display("FAIL basic_latency got=%0d exp=6", done_cyc - start); end
        checks++; if (wr_addr_q.size() !== 4) begin
            errors++; $display("FAIL basic_nwr got=%0d exp=4", wr_addr_q.size()); end
        for (int k = 0; k < 4 && k < wr_addr_q.size(); k++) begin
            checks++; if (wr_addr_q[k] !== 10'(20 + k) || wr_data_q[k] !== 32'hA0 + 32'(k)
                          || wr_we_q[k] !== 4'hF) begin
                errors++; $display("FAIL basic_wr%0d got=%0d/%h/%h exp=%0d/%h/f", k,
                                   wr_addr_q[k], wr_data_q[k], wr_we_q[k], 20 + k, 32'hA0 + 32'(k)); end
        end
    endtask

    task automatic test_backpressure();
        logic en_exp;
        clear_logs();
        @(posedge clk); #1;
        fill_req = 1'b1; fill_addr = 32'h4000_0008; fill_line = 8'd2;
        be_ready = 1'b0; be_rvalid = 1'b0; be_rdata = 32'h0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            fill_req  = 1'b0;
            be_ready  = (c >= 4);
            be_rvalid = (c >= 5 && c <= 14 && (c - 5) % 3 == 0);
            be_rdata  = be_rvalid ? 32'hB0 + 32'((c - 5) / 3) : 32'hBAD0_0000 + 32'(c);
            @(negedge clk);
            en_exp = (c >= 6 && c <= 15 && (c - 6) % 3 == 0);
            checks++; if (be_valid !== (c <= 4)) begin
                errors++; $display("FAIL bp_valid c=%0d got=%b exp=%b", c, be_valid, (c <= 4)); end
            if (c <= 4) begin
                checks++; if (be_addr !== 32'h4000_0000) begin
                    errors++; $display("FAIL bp_be_addr c=%0d got=%h exp=40000000", c, be_addr); end
            end
            checks++; if (ram_en !== en_exp) begin
                errors++; $display("FAIL bp_ram_en c=%0d got=%b exp=%b", c, ram_en, en_exp); end
            checks++; if (fill_done !== (c == 15)) begin
                errors++; $display("FAIL bp_done c=%0d got=%b exp=%b", c, fill_done, (c == 15)); end
            if (c == 7) begin
                checks++; if (ram_addr !== 10'd8 || ram_data !== 32'hB0 || ram_we !== 4'h0) begin
                    errors++; $display("FAIL bp_hold got=%0d/%h/%h exp=8/b0/0", ram_addr, ram_data, ram_we); end
            end
        end
        checks++; if (wr_addr_q.size() !== 4) begin
            errors++; $display("FAIL bp_nwr got=%0d exp=4", wr_addr_q.size()); end
        for (int k = 0; k < 4 && k < wr_addr_q.size(); k++) begin
            checks++; if (wr_addr_q[k] !== 10'(8 + k) || wr_data_q[k] !== 32'hB0 + 32'(k)) begin
                errors++; $display("FAIL bp_wr%0d got=%0d/%h exp=%0d/%h", k,
                                   wr_addr_q[k], wr_data_q[k], 8 + k, 32'hB0 + 32'(k)); end
        end
    endtask

    task automatic test_ignored_inputs();
        clear_logs();
        @(posedge clk); #1;
        fill_req = 1'b1; fill_addr = 32'h0000_0100; fill_line = 8'd3;
        be_ready = 1'b0; be_rvalid = 1'b0; be_rdata = 32'h0;
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1;
            fill_req  = (c <= 9);
            fill_addr = 32'h0000_9990; fill_line = 8'd9;
            be_ready  = (c >= 4);
            be_rvalid = (c == 1 || c == 3 || (c >= 5 && c <= 8));
            be_rdata  = (c >= 5) ? 32'hC0 + 32'(c - 5) : 32'hBAD;
            @(negedge clk);
            if (c == 5) begin
                checks++; if (wr_addr_q.size() !== 0) begin
                    errors++; $display("FAIL ign_req_write got=%0d exp=0", wr_addr_q.size()); end
            end
            if (c <= 4) begin
                checks++; if (be_addr !== 32'h0000_0100) begin
                    errors++; $display("FAIL ign_be_addr c=%0d got=%h exp=00000100", c, be_addr); end
            end
            checks++; if (fill_busy !== (c <= 9)) begin
                errors++; $display("FAIL ign_busy c=%0d got=%b exp=%b", c, fill_busy, (c <= 9)); end
        end
        checks++; if (req_cnt !== 1) begin
            errors++; $display("FAIL ign_req_cnt got=%0d exp=1", req_cnt); end
        checks++; if (done_cnt !== 1) begin
            errors++; $display("FAIL ign_done_cnt got=%0d exp=1", done_cnt); end
        checks++; if (wr_addr_q.size() !== 4) begin
            errors++; $display("FAIL ign_nwr got=%0d exp=4", wr_addr_q.size()); end
        for (int k = 0; k < 4 && k < wr_addr_q.size(); k++) begin
            checks++; if (wr_addr_q[k] !== 10'(12 + k) || wr_data_q[k] !== 32'hC0 + 32'(k)) begin
                errors++; $display("FAIL ign_wr%0d got=%0d/%h exp=%0d/%h", k,
                                   wr_addr_q[k], wr_data_q[k], 12 + k, 32'hC0 + 32'(k)); end
        end
        fill_req = 1'b0; be_ready = 1'b0; be_rvalid = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        clear_logs();
        @(posedge clk); #1;
        fill_req = 1'b1; fill_addr = 32'h0; fill_line = 8'd7;
        be_ready = 1'b1; be_rvalid = 1'b1; be_rdata = 32'h0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            fill_req = 1'b0;
            be_rdata = 32'hD0 + 32'(c - 2);
        end
        @(negedge clk); #1;
        arst_n = 1'b0;
        #1;
        checks++; if ({fill_busy, fill_done, be_valid, ram_en, ram_we} !== 8'h00) begin
            errors++; $display("FAIL rst_mid_flags got=%b exp=0", {fill_busy, fill_done, be_valid, ram_en, ram_we}); end
        checks++; if ({be_addr, ram_addr, ram_data} !== 74'h0) begin
            errors++; $display("FAIL rst_mid_buses got=%h exp=0", {be_addr, ram_addr, ram_data}); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (wr_addr_q.size() !== 2) begin
            errors++; $display("FAIL rst_mid_nwr got=%0d exp=2", wr_addr_q.size()); end
        @(posedge clk); #1;
        arst_n = 1'b1; be_rvalid = 1'b0; be_ready = 1'b0;
        clear_logs();
        run_fast_fill(8'd1, 32'h0000_0080, 32'hE0);
        checks++; if (wr_addr_q.size() !== 4) begin
            errors++; $display("FAIL rst_refill_nwr got=%0d exp=4", wr_addr_q.size()); end
        for (int k = 0; k < 4 && k < wr_addr_q.size(); k++) begin
            checks++; if (wr_addr_q[k] !== 10'(4 + k) || wr_data_q[k] !== 32'hE0 + 32'(k)) begin
                errors++; $display("FAIL rst_refill_wr%0d got=%0d/%h exp=%0d/%h", k,
                                   wr_addr_q[k], wr_data_q[k], 4 + k, 32'hE0 + 32'(k)); end
        end
    endtask

    task automatic test_wrap_back_to_back();
        clear_logs();
        run_fast_fill(8'd255, 32'hFFFF_FFF4, 32'h50);
        checks++; if (be_addr !== 32'hFFFF_FFF0) begin
            errors++; $display("FAIL wrap_be_addr got=%h exp=fffffff0", be_addr); end
        run_fast_fill(8'd0, 32'h0000_0000, 32'h60);
        checks++; if (wr_addr_q.size() !== 8) begin
            errors++; $display("FAIL wrap_nwr got=%0d exp=8", wr_addr_q.size()); end
        for (int k = 0; k < 8 && k < wr_addr_q.size(); k++) begin
            checks++; if (wr_addr_q[k] !== ((k < 4) ? 10'(1020 + k) : 10'(k - 4))) begin
                errors++; $display("FAIL wrap_wr%0d got=%0d", k, wr_addr_q[k]); end
        end
        checks++; if (done_cnt !== 2) begin
            errors++; $display("FAIL wrap_done_cnt got=%0d exp=2", done_cnt); end
    endtask

`ifdef IOB_CACHE_LINE_FILL_ERR_EN
    task automatic test_error_beat();
        clear_logs();
        @(posedge clk); #1;
        fill_req = 1'b1; fill_addr = 32'h200; fill_line = 8'd6;
        be_ready = 1'b1; be_rvalid = 1'b1; be_rdata = 32'h0; be_rerr = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            fill_req  = 1'b0;
            be_rerr   = (c == 3);
            be_rdata  = 32'hF0 + 32'(c - 2);
            be_rvalid = (c <= 5);
            @(negedge clk);
            checks++; if (fill_err !== (c == 4) || fill_done !== (c == 4)) begin
                errors++; $display("FAIL err_pulse c=%0d got=%b%b exp=%b", c, fill_err, fill_done, (c == 4)); end
            checks++; if (fill_busy !== (c <= 4)) begin
                errors++; $display("FAIL err_busy c=%0d got=%b exp=%b", c, fill_busy, (c <= 4)); end
        end
        checks++; if (wr_addr_q.size() !== 1) begin
            errors++; $display("FAIL err_nwr got=%0d exp=1", wr_addr_q.size()); end
        if (wr_addr_q.size() > 0) begin
            checks++; if (wr_addr_q[0] !== 10'd24 || wr_data_q[0] !== 32'hF0) begin
                errors++; $display("FAIL err_wr0 got=%0d/%h exp=24/f0", wr_addr_q[0], wr_data_q[0]); end
        end
        be_rerr = 1'b0; be_ready = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_ignored_inputs();
        test_reset_mid_fill();
        test_wrap_back_to_back();
`ifdef IOB_CACHE_LINE_FILL_ERR_EN
        test_error_beat();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
